// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, keeps at most one imem request in flight, and buffers returned words.
// Optional performance counters are enabled with `define IF_PERF_CNT_EN.
`timescale 1ns/1ps
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [15:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [15:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [15:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [15:0] fetch_pc_o,
  output logic [15:0] fetch_instr_o,
  input  logic        decode_ready_i
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] bubble_cnt_o
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t           state;
  logic [15:0]      fetch_pc;
  logic [15:0]      tag_pc;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [15:0]      ent_pc    [DEPTH];
  logic [15:0]      ent_instr [DEPTH];

  logic [CNT_W-1:0] used;
  logic             issue;
  logic             grant;
  logic             push;
  logic             pop;
  logic             pending;

  // An in-flight request reserves a buffer slot, including the one returning this cycle.
  assign used    = count + CNT_W'(state == ST_WAIT);
  assign issue   = rst_ni && !redirect_i
                   && ((state == ST_IDLE) || ((state == ST_WAIT) && imem_rvalid_i))
                   && (used < CNT_W'(DEPTH));
  assign grant   = issue && imem_gnt_i;
  assign push    = (state == ST_WAIT) && imem_rvalid_i && !redirect_i;
  assign pop     = instr_valid_o && decode_ready_i;
  assign pending = ((state == ST_WAIT) || (state == ST_DROP)) && !imem_rvalid_i;

  assign imem_req_o    = issue;
  assign imem_addr_o   = fetch_pc;
  assign instr_valid_o = (count != '0) && !redirect_i;
  assign fetch_pc_o    = ent_pc[rd_ptr];
  assign fetch_instr_o = ent_instr[rd_ptr];

  // PC, request FSM and FIFO bookkeeping; redirect overrides everything.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      tag_pc   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_pc[i]    <= '0;
        ent_instr[i] <= '0;
      end
    end else if (redirect_i) begin
      state    <= pending ? ST_DROP : ST_IDLE;
      fetch_pc <= redirect_pc_i;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (grant) begin
        tag_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + PC_STEP;
      end
      if (push) begin
        ent_pc[wr_ptr]    <= tag_pc;
        ent_instr[wr_ptr] <= imem_rdata_i;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      unique case (state)
        ST_IDLE: if (grant) state <= ST_WAIT;
        ST_WAIT: if (imem_rvalid_i) state <= grant ? ST_WAIT : ST_IDLE;
        ST_DROP: if (imem_rvalid_i) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  // Decode handshakes and decoder-starved cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      if (pop) fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (decode_ready_i && !instr_valid_o) bubble_cnt_o <= bubble_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: cycle table, reset corner, wrap instance, and random traffic vs a stream-level model.
`timescale 1ns/1ps
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, gnt, rvalid, redirect, valid, ready;
  logic [15:0] addr, rdata, rpc, pc, instr;
  logic        req2, valid2;
  logic [15:0] addr2, pc2, instr2;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fcnt, bcnt, fcnt2, bcnt2;
  int unsigned m_fetch = 0;
  int unsigned m_bubble = 0;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .redirect_i(redirect), .redirect_pc_i(rpc),
    .instr_valid_o(valid), .fetch_pc_o(pc), .fetch_instr_o(instr),
    .decode_ready_i(ready)
`ifdef IF_PERF_CNT_EN
    , .fetch_cnt_o(fcnt), .bubble_cnt_o(bcnt)
`endif
  );

  fetch_stage #(.RESET_PC(16'hFFFC)) dut_wrap (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_req_o(req2), .imem_addr_o(addr2), .imem_gnt_i(1'b1),
    .imem_rvalid_i(1'b1), .imem_rdata_i(16'hBEEF),
    .redirect_i(1'b0), .redirect_pc_i(16'h0000),
    .instr_valid_o(valid2), .fetch_pc_o(pc2), .fetch_instr_o(instr2),
    .decode_ready_i(1'b1)
`ifdef IF_PERF_CNT_EN
    , .fetch_cnt_o(fcnt2), .bubble_cnt_o(bcnt2)
`endif
  );

  typedef struct {
    logic        gnt, rv;
    logic [15:0] rdata;
    logic        redir;
    logic [15:0] rpc;
    logic        rdy;
    logic        req;
    logic [15:0] addr;
    logic        val;
    logic [15:0] pc, instr;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    int          due;
  } pend_t;

  vec_t        tbl[21];
  pend_t       pend[$];
  logic [15:0] wrap_exp[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic g, input logic r, input logic [15:0] d, input logic rd,
                             input logic [15:0] rp, input logic rdy, input logic q,
                             input logic [15:0] a, input logic vl, input logic [15:0] p,
                             input logic [15:0] ins);
    vec_t t;
    t.gnt = g; t.rv = r; t.rdata = d; t.redir = rd; t.rpc = rp; t.rdy = rdy;
    t.req = q; t.addr = a; t.val = vl; t.pc = p; t.instr = ins;
    return t;
  endfunction

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return a ^ 16'hA55A;
  endfunction

  task automatic perf_sample();
`ifdef IF_PERF_CNT_EN
    if (valid && ready) m_fetch++;
    if (ready && !valid) m_bubble++;
`endif
  endtask

  initial begin
    logic [15:0] exp_addr, exp_pc;
    int          delivered;

    // Stream at 1-cycle latency, stall to full, drain, redirect with response + handshake, redirect while outstanding.
    tbl[0]  = v(1, 0, 16'h0000, 0, 16'h0000, 1,  1, 16'h0000, 0, 16'h0000, 16'h0000);
    tbl[1]  = v(1, 1, 16'h3000, 0, 16'h0000, 1,  1, 16'h0002, 0, 16'h0000, 16'h0000);
    tbl[2]  = v(1, 1, 16'h3002, 0, 16'h0000, 1,  1, 16'h0004, 1, 16'h0000, 16'h3000);
    tbl[3]  = v(1, 1, 16'h3004, 0, 16'h0000, 1,  1, 16'h0006, 1, 16'h0002, 16'h3002);
    tbl[4]  = v(1, 1, 16'h3006, 0, 16'h0000, 0,  1, 16'h0008, 1, 16'h0004, 16'h3004);
    tbl[5]  = v(1, 1, 16'h3008, 0, 16'h0000, 0,  1, 16'h000A, 1, 16'h0004, 16'h3004);
    tbl[6]  = v(1, 1, 16'h300A, 0, 16'h0000, 0,  0, 16'h000C, 1, 16'h0004, 16'h3004);
    tbl[7]  = v(1, 0, 16'h0000, 0, 16'h0000, 0,  0, 16'h000C, 1, 16'h0004, 16'h3004);
    tbl[8]  = v(1, 0, 16'h0000, 0, 16'h0000, 1,  0, 16'h000C, 1, 16'h0004, 16'h3004);
    tbl[9]  = v(1, 0, 16'h0000, 0, 16'h0000, 1,  1, 16'h000C, 1, 16'h0006, 16'h3006);
    tbl[10] = v(1, 0, 16'h0000, 0, 16'h0000, 1,  0, 16'h000E, 1, 16'h0008, 16'h3008);
    tbl[11] = v(1, 1, 16'h300C, 1, 16'h0100, 1,  0, 16'h000E, 0, 16'h0000, 16'h0000);
    tbl[12] = v(0, 0, 16'h0000, 0, 16'h0000, 1,  1, 16'h0100, 0, 16'h0000, 16'h0000);
    tbl[13] = v(1, 0, 16'h0000, 0, 16'h0000, 1,  1, 16'h0100, 0, 16'h0000, 16'h0000);
    tbl[14] = v(1, 0, 16'h0000, 1, 16'h0200, 1,  0, 16'h0102, 0, 16'h0000, 16'h0000);
    tbl[15] = v(1, 0, 16'h0000, 0, 16'h0000, 1,  0, 16'h0200, 0, 16'h0000, 16'h0000);
    tbl[16] = v(1, 1, 16'h3100, 0, 16'h0000, 1,  0, 16'h0200, 0, 16'h0000, 16'h0000);
    tbl[17] = v(1, 0, 16'h0000, 0, 16'h0000, 1,  1, 16'h0200, 0, 16'h0000, 16'h0000);
    tbl[18] = v(0, 1, 16'h3200, 0, 16'h0000, 1,  1, 16'h0202, 0, 16'h0000, 16'h0000);
    tbl[19] = v(0, 0, 16'h0000, 0, 16'h0000, 1,  1, 16'h0202, 1, 16'h0200, 16'h3200);
    tbl[20] = v(0, 0, 16'h0000, 0, 16'h0000, 1,  1, 16'h0202, 0, 16'h0000, 16'h0000);
    wrap_exp[0] = 16'hFFFC;
    wrap_exp[1] = 16'hFFFE;
    wrap_exp[2] = 16'h0000;

    rst_n = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = '0; redirect = 1'b0; rpc = '0; ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset req", req, 0);
    chk("reset addr", addr, 16'h0000);
    chk("reset valid", valid, 0);
    chk("reset pc", pc, 16'h0000);
    chk("reset instr", instr, 16'h0000);
    chk("reset wrap addr", addr2, 16'hFFFC);
    chk("reset wrap req", req2, 0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 21; i++) begin
      gnt = tbl[i].gnt; rvalid = tbl[i].rv; rdata = tbl[i].rdata;
      redirect = tbl[i].redir; rpc = tbl[i].rpc; ready = tbl[i].rdy;
      #1;
      chk($sformatf("row%0d req", i), req, tbl[i].req);
      chk($sformatf("row%0d addr", i), addr, tbl[i].addr);
      chk($sformatf("row%0d valid", i), valid, tbl[i].val);
      if (tbl[i].val) begin
        chk($sformatf("row%0d pc", i), pc, tbl[i].pc);
        chk($sformatf("row%0d instr", i), instr, tbl[i].instr);
      end
      if (i < 3) begin
        chk($sformatf("wrap%0d addr", i), addr2, wrap_exp[i]);
        chk($sformatf("wrap%0d req", i), req2, 1);
      end
      if (i == 2) chk("wrap head pc", pc2, 16'hFFFC);
      @(negedge clk);
    end

    // Reset while a request is outstanding, then a stale response after release.
    gnt = 1'b1; rvalid = 1'b0; redirect = 1'b0; ready = 1'b1;
    #1;
    chk("midrst grant addr", addr, 16'h0202);
    @(negedge clk);
    rst_n = 1'b0; gnt = 1'b0;
    #1;
    chk("midrst req", req, 0);
    chk("midrst addr", addr, 16'h0000);
    chk("midrst valid", valid, 0);
`ifdef IF_PERF_CNT_EN
    chk("midrst fetch_cnt", fcnt, 0);
    chk("midrst bubble_cnt", bcnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1; rvalid = 1'b1; rdata = 16'h1234;
    #1;
    chk("stale req", req, 1);
    chk("stale addr", addr, 16'h0000);
`ifdef IF_PERF_CNT_EN
    chk("stale fetch_cnt", fcnt, 0);
    chk("stale bubble_cnt", bcnt, 0);
`endif
    perf_sample();
    @(negedge clk);
    rvalid = 1'b0;
    #1;
    chk("stale ignored valid", valid, 0);
    chk("stale next addr", addr, 16'h0000);
    perf_sample();

    // Random traffic: deliveries must form the sequential PC stream restarted at each redirect.
    exp_addr = 16'h0000;
    exp_pc = 16'h0000;
    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (pend.size() > 0 && pend[0].due <= c) begin
        rvalid = 1'b1;
        rdata = mem_f(pend[0].addr);
      end else begin
        rvalid = 1'b0;
        rdata = 16'($urandom);
      end
      gnt = ($urandom_range(0, 3) != 0);
      ready = ((c % 256) < 48) ? 1'b0 : ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 31) == 0);
      rpc = 16'($urandom) & 16'hFFFE;
      #1;
      if (redirect) begin
        chk("redirect req", req, 0);
        chk("redirect valid", valid, 0);
      end else begin
        if (req && gnt) begin
          chk("rand addr", addr, exp_addr);
          chk("rand single outstanding", 32'(pend.size()) - 32'(rvalid), 0);
          exp_addr = exp_addr + 16'd2;
          pend.push_back('{addr: addr, due: c + int'($urandom_range(1, 3))});
        end
        if (valid && ready) begin
          chk("rand pc", pc, exp_pc);
          chk("rand instr", instr, mem_f(exp_pc));
          exp_pc = exp_pc + 16'd2;
          delivered++;
        end
      end
      perf_sample();
      if (rvalid) void'(pend.pop_front());
      if (redirect) begin
        exp_addr = rpc;
        exp_pc = rpc;
      end
    end
    @(negedge clk);
    gnt = 1'b0; rvalid = 1'b0; redirect = 1'b0;
    #1;
    chk("rand throughput", delivered > 200, 1);
`ifdef IF_PERF_CNT_EN
    chk("fetch_cnt", fcnt, m_fetch);
    chk("bubble_cnt", bcnt, m_bubble);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
